// File: rtl/ps2_mouse_packet_rx.sv
// PS/2 mouse receiver: glitch-filtered 11-bit frame deserialiser feeding a
// 3-byte packet assembler that drives X/Y deltas, buttons and a toggle strobe.
module ps2_mouse_packet_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [8:0] mouse_x,
  output logic [8:0] mouse_y,
  output logic       mouse_left,
  output logic       mouse_right,
  output logic       mouse_middle,
  output logic       input_pulse,
  output logic       frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic [1:0]    clk_sync, data_sync;
  logic          filt, filt_d;
  logic [FW-1:0] filt_cnt;
  logic          fall, din;

  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [1:0]    idx;
  logic [7:0]    status, xbyte;
  logic [TW-1:0] wd;
  logic          byte_ok;

  assign fall    = filt_d & ~filt;
  assign din     = data_sync[1];
  assign byte_ok = din & (^{shreg, par});

  // Overflow wins over the byte value: clamp to the extreme of the sign.
  function automatic logic [8:0] sat(input logic s, input logic ovf, input logic [7:0] b);
    if (ovf) return s ? 9'h100 : 9'h0FF;
    return {s, b};
  endfunction

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt      <= 1'b1;
      filt_d    <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      filt_d    <= filt;
      if (clk_sync[1] != filt) begin
        if (filt_cnt == FW'(FILTER_LEN - 1)) begin
          filt     <= clk_sync[1];
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      par          <= 1'b0;
      idx          <= '0;
      status       <= '0;
      xbyte        <= '0;
      wd           <= '0;
      mouse_x      <= '0;
      mouse_y      <= '0;
      mouse_left   <= 1'b0;
      mouse_right  <= 1'b0;
      mouse_middle <= 1'b0;
      input_pulse  <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (fall) begin
        wd <= '0;
        case (state)
          IDLE: if (!din) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
          DATA: begin
            shreg   <= {din, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= din;
            state <= STOP;
          end
          default: begin
            state <= IDLE;
            if (!byte_ok) begin
              idx       <= '0;
              frame_err <= 1'b1;
            end else begin
              case (idx)
                2'd0: begin
                  // Status byte must carry the always-one bit; otherwise resync.
                  if (!shreg[3]) frame_err <= 1'b1;
                  else begin
                    status <= shreg;
                    idx    <= 2'd1;
                  end
                end
                2'd1: begin
                  xbyte <= shreg;
                  idx   <= 2'd2;
                end
                default: begin
                  mouse_x      <= sat(status[4], status[6], xbyte);
                  mouse_y      <= sat(status[5], status[7], shreg);
                  mouse_left   <= status[0];
                  mouse_right  <= status[1];
                  mouse_middle <= status[2];
                  input_pulse  <= ~input_pulse;
                  idx          <= 2'd0;
                end
              endcase
            end
          end
        endcase
      end else if (state == IDLE && idx == 2'd0) begin
        wd <= '0;
      end else if (wd == TW'(TIMEOUT - 1)) begin
        wd        <= '0;
        state     <= IDLE;
        idx       <= 2'd0;
        frame_err <= 1'b1;
      end else begin
        wd <= wd + 1'b1;
      end
    end
  end
endmodule
